// File: rtl/decode_dispatch_scheduler.sv
// Decode-stage dispatch scheduler: round-robin grant among format decoders
// into a small in-order FIFO, with the head issued to its functional unit.
//
// Handshakes (valid/ready): a decoder packet transfers on the edge where
// dec_valid_i[k] and dec_grant_o[k] are both 1; a FIFO head transfers on
// the edge where issue_valid_o and unit_ready_i[issue_unit_o] are both 1.
// A valid source holds its data stable until it transfers; the ready side
// may change freely and never depends on the source's valid in a loop.
module decode_dispatch_scheduler #(
    parameter int num_decoders  = 4,
    parameter int payload_width = 23,
    parameter int unit_width    = 3,
    parameter int num_units     = 5,
    parameter int fifo_depth    = 4
) (
    input  logic                                  clock_i,
    input  logic                                  reset_i,
    input  logic [num_decoders-1:0]               dec_valid_i,
    input  logic [num_decoders*payload_width-1:0] dec_payload_i,
    input  logic [num_decoders*unit_width-1:0]    dec_unit_i,
    output logic [num_decoders-1:0]               dec_grant_o,
    output logic                                  stall_o,
    output logic                                  issue_valid_o,
    output logic [payload_width-1:0]              issue_payload_o,
    output logic [unit_width-1:0]                 issue_unit_o,
    input  logic [num_units-1:0]                  unit_ready_i,
    output logic                                  err_o,
    output logic [$clog2(fifo_depth):0]           count_o
);

    localparam int aw = $clog2(fifo_depth);
    localparam int cw = aw + 1;
    localparam int rw = (num_decoders > 1) ? $clog2(num_decoders) : 1;

    logic [payload_width-1:0] payload_mem [fifo_depth];
    logic [unit_width-1:0]    unit_mem    [fifo_depth];
    logic [aw-1:0]            head;
    logic [aw-1:0]            tail;
    logic [cw-1:0]            count;
    logic [rw-1:0]            rr_ptr;

    logic                     non_empty;
    logic                     code_ok;
    logic                     sel_ready;
    logic                     pop;
    logic                     drop;
    logic                     deq;
    logic                     push_en;
    logic                     found;
    logic                     push;
    logic [rw-1:0]            winner;
    logic [rw-1:0]            rr_next;
    logic [cw-1:0]            count_next;
    logic [payload_width-1:0] win_payload;
    logic [unit_width-1:0]    win_unit;

    assign count_o         = count;
    assign issue_payload_o = payload_mem[head];
    assign issue_unit_o    = unit_mem[head];

    // Head qualification: valid code issues on its unit's ready, an invalid code is dropped.
    always_comb begin
        non_empty = (count != '0);
        code_ok   = ({1'b0, issue_unit_o} < (unit_width + 1)'(num_units));
        sel_ready = 1'b0;
        for (int u = 0; u < num_units; u++) begin
            if (issue_unit_o == unit_width'(u)) begin
                sel_ready = unit_ready_i[u];
            end
        end
        issue_valid_o = non_empty && code_ok;
        pop           = issue_valid_o && sel_ready;
        drop          = non_empty && !code_ok;
        deq           = pop || drop;
        push_en       = (count < cw'(fifo_depth)) || deq;
    end

    // Round-robin search starting at rr_ptr; grant only when the FIFO can take the packet.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < num_decoders; i++) begin
            if (!found && dec_valid_i[(int'(rr_ptr) + i) % num_decoders]) begin
                found  = 1'b1;
                winner = rw'((int'(rr_ptr) + i) % num_decoders);
            end
        end
        push        = found && push_en && !reset_i;
        dec_grant_o = '0;
        if (push) begin
            dec_grant_o[winner] = 1'b1;
        end
        rr_next     = (winner == rw'(num_decoders - 1)) ? '0 : winner + 1'b1;
        win_payload = dec_payload_i[int'(winner)*payload_width +: payload_width];
        win_unit    = dec_unit_i[int'(winner)*unit_width +: unit_width];
        count_next  = count + cw'(push) - cw'(deq);
    end

    // Packet storage: written at the tail on a grant; contents need no reset.
    always_ff @(posedge clock_i) begin
        if (push) begin
            payload_mem[tail] <= win_payload;
            unit_mem[tail]    <= win_unit;
        end
    end

    // Pointers, occupancy, arbitration pointer and registered status flags.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rr_ptr  <= '0;
            stall_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            if (push) begin
                tail   <= tail + 1'b1;
                rr_ptr <= rr_next;
            end
            if (deq) begin
                head <= head + 1'b1;
            end
            count   <= count_next;
            stall_o <= (count_next == cw'(fifo_depth));
            err_o   <= drop;
        end
    end

endmodule

// File: tb/tb_decode_dispatch_scheduler.sv
// Bench for decode_dispatch_scheduler: directed scenarios followed by random
// traffic, all checked against a queue-based model of the scheduler.
module tb_decode_dispatch_scheduler;

    localparam int ND    = 4;
    localparam int PW    = 23;
    localparam int UW    = 3;
    localparam int NU    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic              clock_i = 1'b0;
    logic              reset_i;
    logic [ND-1:0]     dec_valid;
    logic [ND*PW-1:0]  dec_payload;
    logic [ND*UW-1:0]  dec_unit;
    logic [ND-1:0]     dec_grant_o;
    logic              stall_o;
    logic              issue_valid_o;
    logic [PW-1:0]     issue_payload_o;
    logic [UW-1:0]     issue_unit_o;
    logic [NU-1:0]     unit_ready;
    logic              err_o;
    logic [CW-1:0]     count_o;

    int n_checks = 0;
    int n_errors = 0;

    // model state: queue of {unit, payload}
    logic [UW+PW-1:0] exp_q[$];
    int               rr;
    bit               exp_stall;
    bit               exp_err;
    logic [ND-1:0]    m_grant;
    bit               m_valid;
    bit               m_deq;
    bit               m_drop;
    int               m_win;
    logic [ND-1:0]    obs_grant;
    int               err_seen;
    bit               checks_on;

    decode_dispatch_scheduler #(
        .num_decoders(ND), .payload_width(PW), .unit_width(UW),
        .num_units(NU), .fifo_depth(DEPTH)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .dec_valid_i(dec_valid),
        .dec_payload_i(dec_payload),
        .dec_unit_i(dec_unit),
        .dec_grant_o(dec_grant_o),
        .stall_o(stall_o),
        .issue_valid_o(issue_valid_o),
        .issue_payload_o(issue_payload_o),
        .issue_unit_o(issue_unit_o),
        .unit_ready_i(unit_ready),
        .err_o(err_o),
        .count_o(count_o)
    );

    // clock
    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input int k, input logic [PW-1:0] p, input logic [UW-1:0] u);
        dec_valid[k]          = 1'b1;
        dec_payload[k*PW +: PW] = p;
        dec_unit[k*UW +: UW]    = u;
    endtask

    // model: what the scheduler should do this cycle given queue and inputs
    task automatic model_comb();
        int hu;
        m_grant = '0;
        m_valid = 0;
        m_deq   = 0;
        m_drop  = 0;
        m_win   = -1;
        if (exp_q.size() > 0) begin
            hu = int'(exp_q[0][UW+PW-1:PW]);
            if (hu < NU) begin
                m_valid = 1;
                m_deq   = unit_ready[hu];
            end else begin
                m_drop = 1;
                m_deq  = 1;
            end
        end
        for (int i = 0; i < ND; i++) begin
            if (m_win < 0 && dec_valid[(rr + i) % ND]) m_win = (rr + i) % ND;
        end
        if (m_win >= 0 && (exp_q.size() < DEPTH || m_deq) && !reset_i) m_grant[m_win] = 1'b1;
    endtask

    task automatic model_edge();
        if (reset_i) begin
            exp_q.delete();
            rr        = 0;
            exp_stall = 0;
            exp_err   = 0;
        end else begin
            if (m_deq) void'(exp_q.pop_front());
            if (m_grant != '0) begin
                exp_q.push_back({dec_unit[m_win*UW +: UW], dec_payload[m_win*PW +: PW]});
                rr = (m_win + 1) % ND;
            end
            exp_err   = m_drop;
            exp_stall = (exp_q.size() == DEPTH);
        end
    endtask

    // one clock: check outputs mid-cycle, then advance model at the edge
    task automatic cycle();
        @(negedge clock_i);
        model_comb();
        obs_grant = dec_grant_o;
        if (checks_on) begin
            chk("grant", 32'(dec_grant_o), 32'(m_grant));
            chk("issue_valid", 32'(issue_valid_o), 32'(m_valid));
            chk("count", 32'(count_o), 32'(exp_q.size()));
            chk("stall", 32'(stall_o), 32'(exp_stall));
            chk("err", 32'(err_o), 32'(exp_err));
            if (exp_q.size() > 0) begin
                chk("issue_payload", 32'(issue_payload_o), 32'(exp_q[0][PW-1:0]));
                chk("issue_unit", 32'(issue_unit_o), 32'(exp_q[0][UW+PW-1:PW]));
            end
            if (err_o === 1'b1) err_seen++;
        end
        @(posedge clock_i);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        dec_valid = '0;
        reset_i   = 1'b1;
        cycle();
        reset_i   = 1'b0;
    endtask

    task automatic clear_granted();
        for (int k = 0; k < ND; k++) if (m_grant[k]) dec_valid[k] = 1'b0;
    endtask

    initial begin
        reset_i     = 1'b1;
        dec_valid   = '0;
        dec_payload = '0;
        dec_unit    = '0;
        unit_ready  = '1;
        checks_on   = 0;
        err_seen    = 0;
        repeat (2) @(posedge clock_i);
        #1;
        exp_q.delete();
        rr = 0; exp_stall = 0; exp_err = 0;
        checks_on = 1;
        chk("rst_count", 32'(count_o), 0);
        chk("rst_stall", 32'(stall_o), 0);
        chk("rst_err", 32'(err_o), 0);
        chk("rst_issue_valid", 32'(issue_valid_o), 0);
        reset_i = 1'b0;

        // single packet from decoder 2
        present(2, 23'h1ABCD, 3'd0);
        cycle();
        chk("t1_grant", 32'(obs_grant), 32'h4);
        clear_granted();
        chk("t1_issue_valid", 32'(issue_valid_o), 1);
        chk("t1_issue_payload", 32'(issue_payload_o), 32'h1ABCD);
        chk("t1_issue_unit", 32'(issue_unit_o), 0);
        cycle();
        chk("t1_count_after", 32'(count_o), 0);

        // all decoders continuously valid, all units ready
        do_reset();
        for (int k = 0; k < ND; k++) present(k, PW'(32'h100 + k), UW'(k));
        for (int c = 0; c < 8; c++) begin
            cycle();
            chk("t2_rr_order", 32'(obs_grant), 32'(1 << (c % ND)));
            chk("t2_count_le1", 32'(count_o <= 1), 1);
        end

        // fill to full with no unit ready, then push and pop together
        do_reset();
        unit_ready = '0;
        present(0, 23'h00010, 3'd1);
        for (int c = 0; c < 4; c++) begin
            cycle();
            present(0, PW'(32'h20 + c), 3'd1);
        end
        chk("t3_count_full", 32'(count_o), 4);
        chk("t3_stall", 32'(stall_o), 1);
        cycle();
        chk("t3_fifth_blocked", 32'(obs_grant), 0);
        unit_ready = '1;
        cycle();
        chk("t3_push_pop_grant", 32'(obs_grant), 1);
        chk("t3_count_stays", 32'(count_o), 4);
        dec_valid = '0;

        // head blocked on unit 3, younger unit-0 entry must wait
        do_reset();
        unit_ready = 5'b10111;
        present(1, 23'h00333, 3'd3);
        cycle();
        present(1, 23'h00444, 3'd0);
        cycle();
        dec_valid = '0;
        cycle();
        cycle();
        chk("t4_blocked_unit", 32'(issue_unit_o), 3);
        chk("t4_blocked_count", 32'(count_o), 2);
        unit_ready = '1;
        cycle();
        chk("t4_second_unit", 32'(issue_unit_o), 0);
        chk("t4_second_payload", 32'(issue_payload_o), 32'h444);
        cycle();

        // invalid code 7 discarded, then unit-1 packet issues
        do_reset();
        err_seen = 0;
        present(0, 23'h00777, 3'd7);
        cycle();
        chk("t5_invalid_not_issued", 32'(issue_valid_o), 0);
        present(0, 23'h00111, 3'd1);
        cycle();
        dec_valid = '0;
        chk("t5_err_pulse", 32'(err_o), 1);
        chk("t5_next_valid", 32'(issue_valid_o), 1);
        chk("t5_next_unit", 32'(issue_unit_o), 1);
        cycle();
        cycle();
        chk("t5_err_once", 32'(err_seen), 1);

        // reset mid-stream with three buffered packets
        do_reset();
        unit_ready = '0;
        present(0, 23'h00001, 3'd2);
        for (int c = 0; c < 3; c++) begin
            cycle();
            present(0, PW'(32'h2 + c), 3'd2);
        end
        chk("t6_count3", 32'(count_o), 3);
        for (int k = 0; k < ND; k++) present(k, PW'(32'h50 + k), 3'd0);
        reset_i = 1'b1;
        cycle();
        chk("t6_grant_in_reset", 32'(obs_grant), 0);
        reset_i = 1'b0;
        chk("t6_count0", 32'(count_o), 0);
        chk("t6_issue_valid0", 32'(issue_valid_o), 0);
        chk("t6_stall0", 32'(stall_o), 0);
        cycle();
        chk("t6_rr_restart", 32'(obs_grant), 1);

        // random traffic
        dec_valid = '0;
        for (int c = 0; c < 400; c++) begin
            reset_i = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < ND; k++) begin
                if (!dec_valid[k] || m_grant[k]) begin
                    dec_valid[k] = ($urandom_range(0, 2) != 0);
                    dec_payload[k*PW +: PW] = PW'($urandom);
                    if ($urandom_range(0, 9) == 0)
                        dec_unit[k*UW +: UW] = UW'($urandom_range(5, 7));
                    else
                        dec_unit[k*UW +: UW] = UW'($urandom_range(0, 4));
                end
            end
            unit_ready = NU'($urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
